// File: rtl/game_mode_fsm.sv
// Game mode sequencer: menu cursor, blanking interval between modes, and game exit.
// Optional per-key debouncing is enabled with the macro KEY_DEBOUNCE_EN.
module game_mode_fsm #(
  parameter int unsigned BLANK_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iKeyUp,
  input  logic       iKeyDown,
  input  logic       iKeySelect,
  input  logic       iKeyBack,
  input  logic       iGameDone,
  output logic [1:0] oGameMode,
  output logic       oCursor,
  output logic       oModeChange
);

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned BLANK_W  = 8;
  localparam int unsigned KEY_UP   = 0;
  localparam int unsigned KEY_DN   = 1;
  localparam int unsigned KEY_SEL  = 2;
  localparam int unsigned KEY_BACK = 3;

  // State encodings double as the oGameMode values.
  typedef enum logic [1:0] {
    MENU     = 2'd0,
    REACTION = 2'd1,
    CHIMP    = 2'd2,
    BLANK    = 2'd3
  } state_e;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] key_prev_q;
  logic [NUM_KEYS-1:0] key_ev;

  assign key_raw = {iKeyBack, iKeySelect, iKeyDown, iKeyUp};

`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned DB_W = 16;

  logic [NUM_KEYS-1:0]           db_lvl_q;
  logic [NUM_KEYS-1:0]           db_lvl_d;
  logic [NUM_KEYS-1:0][DB_W-1:0] db_cnt_q;
  logic [NUM_KEYS-1:0][DB_W-1:0] db_cnt_d;

  // A key's filtered level flips only after DEBOUNCE_CYCLES consecutive clocks at the new level.
  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_raw[k] != db_lvl_q[k]) begin
        if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl_d[k] = key_raw[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  // Filtered levels start high so a key held through reset cannot fake a press.
  always_ff @(posedge clk) begin
    if (iReset) begin
      db_lvl_q <= '1;
      db_cnt_q <= '0;
    end else begin
      db_lvl_q <= db_lvl_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign key_lvl = db_lvl_q;
`else
  assign key_lvl = key_raw;
`endif

  // Rising-edge detect; prev loads 1 in reset so held keys need a release first.
  always_ff @(posedge clk) begin
    if (iReset) begin
      key_prev_q <= '1;
    end else begin
      key_prev_q <= key_lvl;
    end
  end

  assign key_ev = key_lvl & ~key_prev_q;

  state_e               state_q;
  state_e               state_d;
  state_e               target_q;
  state_e               target_d;
  logic                 cursor_q;
  logic                 cursor_d;
  logic                 mode_change_q;
  logic                 mode_change_d;
  logic [BLANK_W-1:0]   blank_cnt_q;
  logic [BLANK_W-1:0]   blank_cnt_d;

  // Next-state logic for the mode sequencer.
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    cursor_d      = cursor_q;
    blank_cnt_d   = blank_cnt_q;
    mode_change_d = 1'b0;
    case (state_q)
      MENU: begin
        if (key_ev[KEY_SEL]) begin
          target_d    = cursor_q ? CHIMP : REACTION;
          state_d     = BLANK;
          blank_cnt_d = '0;
        end else if (key_ev[KEY_UP] ^ key_ev[KEY_DN]) begin
          cursor_d = ~cursor_q;
        end
      end
      BLANK: begin
        if (blank_cnt_q == BLANK_W'(BLANK_CYCLES - 1)) begin
          state_d       = target_q;
          blank_cnt_d   = '0;
          mode_change_d = 1'b1;
        end else begin
          blank_cnt_d = blank_cnt_q + BLANK_W'(1);
        end
      end
      REACTION, CHIMP: begin
        if (key_ev[KEY_BACK] || iGameDone) begin
          target_d    = MENU;
          state_d     = BLANK;
          blank_cnt_d = '0;
        end
      end
      default: begin
        state_d = MENU;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q       <= MENU;
      target_q      <= MENU;
      cursor_q      <= 1'b0;
      mode_change_q <= 1'b0;
      blank_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      cursor_q      <= cursor_d;
      mode_change_q <= mode_change_d;
      blank_cnt_q   <= blank_cnt_d;
    end
  end

  assign oGameMode   = state_q;
  assign oCursor     = cursor_q;
  assign oModeChange = mode_change_q;

endmodule
